// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, oversample default and parity helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned MAX_DATA_W     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Zero-extension to MAX_DATA_W leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready character push channel into the UART TX FIFO.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous DATA_W x DEPTH FIFO with flush, registered level/full/empty; shared by TX and RX.
module uart_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rd_data_c,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       empty_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == LVL_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage needs no reset; only entries below the level are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_c   = mem_q[rd_ptr_q];
  assign level_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign empty_nxt_c = (count_d == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO, optional parity and 1/2 stop bits.
// Define UART_TX_CTS_EN to add the cts_ni flow-control input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tx_enable_i,
  input  logic                       tick_baud_x16_i,
  input  logic                       parity_enable_i,
  input  logic                       parity_odd_i,
  input  logic                       stop2_i,
  uart_tx_fifo_if.slave              wr,
  input  logic                       fifo_clr_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
  output logic                       idle_o,
`ifdef UART_TX_CTS_EN
  input  logic                       cts_ni,
`endif
  output logic                       tx_o
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty, fifo_empty_nxt, fifo_pop;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (fifo_clr_i),
    .push_i      (wr.wr_valid),
    .wr_data_i   (wr.wr_data),
    .pop_i       (fifo_pop),
    .rd_data_c   (fifo_rd_data),
    .level_o     (fifo_level_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  assign wr.wr_ready = ~fifo_full;

  // Bit-time divider: baud tick fires on the oversample strobe that wraps the count.
  logic [CNT_W-1:0] div_q;
  logic             baud_tick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              div_q <= '0;
    else if (!tx_enable_i)    div_q <= '0;
    else if (tick_baud_x16_i) div_q <= (div_q == CNT_W'(OVERSAMPLE-1)) ? '0 : div_q + CNT_W'(1);
  end

  assign baud_tick = tx_enable_i & tick_baud_x16_i & (div_q == CNT_W'(OVERSAMPLE-1));

  logic cts_ok;
`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cts_sync_q <= 2'b11;
    else         cts_sync_q <= {cts_sync_q[0], cts_ni};
  end
  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  logic can_start;
  assign can_start = cts_ok & ~fifo_empty;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              idle_q, idle_d;
  logic              load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      idle_q     <= idle_d;
    end
  end

  // Frame sequencing; every state change happens on a baud tick, or on disable.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    load       = 1'b0;
    fifo_pop   = 1'b0;

    if (!tx_enable_i) begin
      state_d = ST_IDLE;
      tx_d    = 1'b1;
    end else if (baud_tick) begin
      unique case (state_q)
        ST_IDLE: load = can_start;
        ST_START: begin
          state_d   = ST_DATA;
          bit_cnt_d = BIT_W'(DATA_W-1);
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
        ST_DATA: begin
          if (bit_cnt_q == '0) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = stop2_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = stop2_q;
        end
        ST_STOP: begin
          if (stop_cnt_q) begin
            stop_cnt_d = 1'b0;
          end else if (can_start) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase

      // Parity is resolved at load so later config changes cannot affect the frame.
      if (load) begin
        fifo_pop = 1'b1;
        state_d  = ST_START;
        tx_d     = 1'b0;
        shift_d  = fifo_rd_data;
        par_en_d = parity_enable_i;
        par_d    = parity_bit(MAX_DATA_W'(fifo_rd_data), parity_odd_i);
        stop2_d  = stop2_i;
      end
    end
  end

  assign idle_d = (state_d == ST_IDLE) & fifo_empty_nxt;

  assign tx_o   = tx_q;
  assign idle_o = idle_q;

endmodule
